// File: rtl/multi_ch_window_average.sv
// Per-channel block averager over 2^k-sample windows on a tagged, interleaved sample stream.
// Optional feature macro: AVG_ROUND_EN (round half up with saturation instead of truncation).
module multi_ch_window_average #(
  parameter int DATA_IN_WIDTH = 12,
  parameter int NUM_CH        = 4,
  parameter int CH_WIDTH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int MAX_LOG2_WIN  = 9,
  parameter int ACC_WIDTH     = DATA_IN_WIDTH + MAX_LOG2_WIN,
  localparam int K_WIDTH      = $clog2(MAX_LOG2_WIN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic [CH_WIDTH-1:0]      i_ch,
  input  logic [DATA_IN_WIDTH-1:0] i_data,
  input  logic [K_WIDTH-1:0]       i_log2_win,
  input  logic                     i_clear,
  output logic                     o_valid,
  output logic [CH_WIDTH-1:0]      o_ch,
  output logic [DATA_IN_WIDTH-1:0] o_average,
  output logic                     o_first,
  output logic                     o_overrun
);

  localparam int                 CNT_WIDTH = MAX_LOG2_WIN + 1;
  localparam logic [K_WIDTH-1:0] MAX_K     = K_WIDTH'(MAX_LOG2_WIN);
  localparam logic [CH_WIDTH:0]  NUM_CH_L  = (CH_WIDTH + 1)'(NUM_CH);

  logic [ACC_WIDTH-1:0] acc_q [NUM_CH];
  logic [ACC_WIDTH-1:0] acc_d [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [K_WIDTH-1:0]   k_q   [NUM_CH];
  logic [K_WIDTH-1:0]   k_d   [NUM_CH];

  logic                     valid_q, valid_d;
  logic [CH_WIDTH-1:0]      ch_q, ch_d;
  logic [DATA_IN_WIDTH-1:0] avg_q, avg_d;
  logic                     overrun_q, overrun_d;

  logic [NUM_CH-1:0]        hit_ch;
  logic                     tag_ok;
  logic                     accept;
  logic [K_WIDTH-1:0]       k_clamped;
  logic [ACC_WIDTH-1:0]     sel_acc;
  logic [CNT_WIDTH-1:0]     sel_cnt;
  logic [K_WIDTH-1:0]       sel_k;
  logic                     first;
  logic [K_WIDTH-1:0]       k_eff;
  logic [CNT_WIDTH-1:0]     term_cnt;
  logic                     done;
  logic [ACC_WIDTH-1:0]     sum;
  logic [DATA_IN_WIDTH-1:0] avg_now;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_hit
      assign hit_ch[gi] = (i_ch == CH_WIDTH'(gi));
    end
  endgenerate

  assign tag_ok    = ({1'b0, i_ch} < NUM_CH_L);
  assign accept    = i_valid && tag_ok && !i_clear;
  assign k_clamped = (i_log2_win > MAX_K) ? MAX_K : i_log2_win;

  always_comb begin
    sel_acc = '0;
    sel_cnt = '0;
    sel_k   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit_ch[c]) begin
        sel_acc = acc_q[c];
        sel_cnt = cnt_q[c];
        sel_k   = k_q[c];
      end
    end
  end

  // The exponent for a fresh window comes straight from the input so k=0 completes on its first sample.
  assign first    = (sel_cnt == '0);
  assign k_eff    = first ? k_clamped : sel_k;
  assign term_cnt = (CNT_WIDTH'(1) << k_eff) - CNT_WIDTH'(1);
  assign done     = (sel_cnt == term_cnt);
  assign sum      = sel_acc + ACC_WIDTH'(i_data);
  assign o_first  = i_valid && tag_ok && first;

`ifdef AVG_ROUND_EN
  localparam logic [ACC_WIDTH:0] DATA_MAX = (ACC_WIDTH + 1)'((64'd1 << DATA_IN_WIDTH) - 64'd1);
  logic [ACC_WIDTH:0] half;
  logic [ACC_WIDTH:0] sum_rnd;
  logic [ACC_WIDTH:0] q_rnd;

  assign half    = (k_eff == '0) ? '0 : ((ACC_WIDTH + 1)'(1) << (k_eff - K_WIDTH'(1)));
  assign sum_rnd = {1'b0, sum} + half;
  assign q_rnd   = sum_rnd >> k_eff;
  assign avg_now = (q_rnd > DATA_MAX) ? '1 : DATA_IN_WIDTH'(q_rnd);
`else
  assign avg_now = DATA_IN_WIDTH'(sum >> k_eff);
`endif

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_d[c] = acc_q[c];
      cnt_d[c] = cnt_q[c];
      k_d[c]   = k_q[c];
    end
    if (i_clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_d[c] = '0;
        cnt_d[c] = '0;
        k_d[c]   = '0;
      end
    end else if (accept) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hit_ch[c]) begin
          if (first) k_d[c] = k_clamped;
          if (done) begin
            acc_d[c] = '0;
            cnt_d[c] = '0;
          end else begin
            acc_d[c] = sum;
            cnt_d[c] = sel_cnt + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_comb begin
    valid_d   = accept && done;
    ch_d      = (accept && done) ? i_ch : ch_q;
    avg_d     = (accept && done) ? avg_now : avg_q;
    overrun_d = i_clear ? 1'b0 : (overrun_q || (i_valid && !tag_ok));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= '0;
        cnt_q[c] <= '0;
        k_q[c]   <= '0;
      end
      valid_q   <= 1'b0;
      ch_q      <= '0;
      avg_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c] <= acc_d[c];
        cnt_q[c] <= cnt_d[c];
        k_q[c]   <= k_d[c];
      end
      valid_q   <= valid_d;
      ch_q      <= ch_d;
      avg_q     <= avg_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_ch      = ch_q;
  assign o_average = avg_q;
  assign o_overrun = overrun_q;

endmodule
